// File: rtl/alu_uart_sequencer.sv
// Command sequencer between a UART and an operand/opcode latch stage feeding an ALU.
// Assembles A, B and the opcode from received bytes, strobes them onto a shared bus, returns the result byte-wise.
module alu_uart_sequencer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MODE_WIDTH = 6,
    localparam int BUS_WIDTH  = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH,
    localparam int NBYTES     = (DATA_WIDTH + 7) / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_busy,
    output logic [BUS_WIDTH-1:0]  o_data_bus,
    output logic                  o_load_A,
    output logic                  o_load_B,
    output logic                  o_load_op,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_overrun
);

    localparam int SHIFT_W = 8 * NBYTES;
    localparam int CNT_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [3:0] {
        S_GET_A,
        S_LOAD_A,
        S_GET_B,
        S_LOAD_B,
        S_GET_OP,
        S_LOAD_OP,
        S_SETTLE,
        S_CAPTURE,
        S_TX_START,
        S_TX_GUARD,
        S_TX_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [SHIFT_W-1:0]     result_q, result_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   load_a_q, load_a_d;
    logic                   load_b_q, load_b_d;
    logic                   load_op_q, load_op_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   overrun_q, overrun_d;

    logic [SHIFT_W-1:0]     rx_shift;
    logic [DATA_WIDTH-1:0]  operand;
    logic                   rx_accepting;

    // Bytes arrive LSB first, so each new byte enters at the top and the register shifts right.
    assign rx_shift     = SHIFT_W'({i_rx_data, shift_q} >> 8);
    assign operand      = rx_shift[DATA_WIDTH-1:0];
    assign rx_accepting = (state_q == S_GET_A) || (state_q == S_GET_B) || (state_q == S_GET_OP);

    // NOTE: next-state logic is purely combinational with blocking '=' and a default for
    // every *_d first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        result_d   = result_q;
        bus_d      = bus_q;
        load_a_d   = 1'b0;
        load_b_d   = 1'b0;
        load_op_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = i_rx_valid && !rx_accepting;

        case (state_q)
            S_GET_A, S_GET_B: begin
                if (i_rx_valid) begin
                    shift_d = rx_shift;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d = '0;
                        bus_d = BUS_WIDTH'($signed(operand));
                        if (state_q == S_GET_A) begin
                            state_d  = S_LOAD_A;
                            load_a_d = 1'b1;
                        end else begin
                            state_d  = S_LOAD_B;
                            load_b_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_A: state_d = S_GET_B;
            S_LOAD_B: state_d = S_GET_OP;
            S_GET_OP: begin
                if (i_rx_valid) begin
                    bus_d     = BUS_WIDTH'(i_rx_data[MODE_WIDTH-1:0]);
                    load_op_d = 1'b1;
                    state_d   = S_LOAD_OP;
                end
            end
            S_LOAD_OP: state_d = S_SETTLE;
            // The latch stage updates at the end of LOAD_OP; the ALU output is stable one cycle later.
            S_SETTLE:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                result_d = SHIFT_W'(i_alu_result);
                cnt_d    = '0;
                state_d  = S_TX_START;
            end
            S_TX_START: begin
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = result_q[7:0];
                    state_d    = S_TX_GUARD;
                end
            end
            // Busy only rises the cycle after the start pulse, so it is not trusted here.
            S_TX_GUARD: state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!i_tx_busy) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = S_GET_A;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        result_d = result_q >> 8;
                        state_d  = S_TX_START;
                    end
                end
            end
            default: state_d = S_GET_A;
        endcase
    end

    // NOTE: state uses non-blocking '<=' only; reset is synchronous and clears every flop,
    // including the data registers, so a reset mid-command discards all partial work.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_GET_A;
            cnt_q      <= '0;
            shift_q    <= '0;
            result_q   <= '0;
            bus_q      <= '0;
            load_a_q   <= 1'b0;
            load_b_q   <= 1'b0;
            load_op_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            bus_q      <= bus_d;
            load_a_q   <= load_a_d;
            load_b_q   <= load_b_d;
            load_op_q  <= load_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_data_bus = bus_q;
    assign o_load_A   = load_a_q;
    assign o_load_B   = load_b_q;
    assign o_load_op  = load_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_overrun  = overrun_q;

endmodule
